cyclic_bram_sched: RTL and testbench

CYCLIC_BRAM_SCHED -- requirements
Module: cyclic_bram_sched

---
 rtl/cyclic_bram_sched_if.sv | 32 +++
 rtl/cyclic_bram_sched.sv | 166 ++++++++++++++++
 tb/tb_cyclic_bram_sched.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cyclic_bram_sched_if.sv
// cyclic_bram_sched_if -- handshake bundle for cyclic_bram_sched.
//   s_*   : fill beats (payload goes straight to the banks, only control here)
//   cfg_* : read-job descriptor (passes-1, per-pass address window)
//   m_*   : read-data qualifiers aligned to the bank output mux
// master = producer/consumer side, slave = scheduler side.
interface cyclic_bram_sched_if #(
    parameter int R_ADDR_WIDTH = 3,
    parameter int REPEAT_WIDTH = 16
);
    logic                    s_valid;
    logic                    s_ready;
    logic                    s_last;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [REPEAT_WIDTH-1:0] cfg_repeat;
    logic [R_ADDR_WIDTH-1:0] cfg_addr_min;
    logic [R_ADDR_WIDTH-1:0] cfg_addr_max;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_sel;
    logic                    m_last;

    modport master (
        output s_valid, s_last, cfg_valid, cfg_repeat, cfg_addr_min, cfg_addr_max, m_ready,
        input  s_ready, cfg_ready, m_valid, m_sel, m_last
    );

    modport slave (
        input  s_valid, s_last, cfg_valid, cfg_repeat, cfg_addr_min, cfg_addr_max, m_ready,
        output s_ready, cfg_ready, m_valid, m_sel, m_last
    );
endinterface

// File: rtl/cyclic_bram_sched.sv
// cyclic_bram_sched -- ping-pong scheduler for two cyclic BRAM banks.
// One bank fills (wptr) while the other is read (rptr) for repeat+1 passes over
// [addr_min, addr_max]. A LATENCY-deep {valid,sel,last} pipe tracks the bank read
// latency; everything advances only on clken, which drops while the output stalls.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : s_* fill handshake, cfg_* descriptor, m_* output qualifiers
//   clken               : shared bank clock enable
//   bank_w_en/r_en      : per-bank write/read enables
//   bank_resetn_local   : per-bank address reset, low for one cycle after a job
//   bank_addr_min/max   : per-bank latched read window, bank b at [b*W +: W]
// Optional: define CYCLIC_SCHED_STATS_EN to add stat_stall_cycles / stat_passes.
module cyclic_bram_sched #(
    parameter int R_DEPTH      = 8,
    parameter int LATENCY      = 3,
    parameter int REPEAT_WIDTH = 16,
    parameter int R_ADDR_WIDTH = $clog2(R_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    cyclic_bram_sched_if.slave        bus,
    output logic                      clken,
    output logic [1:0]                bank_w_en,
    output logic [1:0]                bank_r_en,
    output logic [1:0]                bank_resetn_local,
    output logic [2*R_ADDR_WIDTH-1:0] bank_addr_min,
    output logic [2*R_ADDR_WIDTH-1:0] bank_addr_max
`ifdef CYCLIC_SCHED_STATS_EN
    ,
    output logic [31:0]               stat_stall_cycles,
    output logic [31:0]               stat_passes
`endif
);
    typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} bank_state_t;

    bank_state_t             state_q [2];
    bank_state_t             state_d [2];
    logic                    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [R_ADDR_WIDTH-1:0] min_q [2];
    logic [R_ADDR_WIDTH-1:0] max_q [2];
    logic [R_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REPEAT_WIDTH-1:0] rep_q, pass_q, pass_d;
    logic [LATENCY:1]        vld_pipe, sel_pipe, lst_pipe;
    logic                    m_vld, s_ok, s_fire, cfg_ok, cfg_fire;
    logic                    rd_fire, pass_end, rd_last;

    // All externally visible outputs are forced to their idle values while rst is
    // high, so the reset state is visible before the first reset edge completes.
    assign m_vld    = vld_pipe[LATENCY] && !rst;
    assign clken    = !(m_vld && !bus.m_ready);
    assign s_ok     = !rst && clken && (state_q[wptr_q] == EMPTY || state_q[wptr_q] == FILL);
    assign s_fire   = s_ok && bus.s_valid;
    assign cfg_ok   = !rst && (state_q[rptr_q] == FULL);
    assign cfg_fire = cfg_ok && bus.cfg_valid;
    assign rd_fire  = !rst && clken && (state_q[rptr_q] == READ);
    assign pass_end = rd_fire && (addr_q == max_q[rptr_q]);
    assign rd_last  = pass_end && (pass_q == rep_q);

    assign bus.s_ready   = s_ok;
    assign bus.cfg_ready = cfg_ok;
    assign bus.m_valid   = m_vld;
    assign bus.m_sel     = sel_pipe[LATENCY] && !rst;
    assign bus.m_last    = lst_pipe[LATENCY] && !rst;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_addr_min[b*R_ADDR_WIDTH +: R_ADDR_WIDTH] = rst ? '0 : min_q[b];
        assign bank_addr_max[b*R_ADDR_WIDTH +: R_ADDR_WIDTH] = rst ? '0 : max_q[b];
    end

    // Fill and read touch disjoint banks: fill only acts on EMPTY/FILL, read only
    // on FULL/READ, so the two updates below never collide on one bank.
    always_comb begin
        state_d           = state_q;
        wptr_d            = wptr_q;
        rptr_d            = rptr_q;
        addr_d            = addr_q;
        pass_d            = pass_q;
        bank_w_en         = '0;
        bank_r_en         = '0;
        bank_resetn_local = rst ? 2'b00 : 2'b11;

        if (s_fire) begin
            bank_w_en[wptr_q] = 1'b1;
            state_d[wptr_q]   = bus.s_last ? FULL : FILL;
            if (bus.s_last)
                wptr_d = !wptr_q;
        end

        if (cfg_fire) begin
            state_d[rptr_q] = READ;
            addr_d          = bus.cfg_addr_min;
            pass_d          = '0;
        end

        if (rd_fire) begin
            bank_r_en[rptr_q] = 1'b1;
            if (pass_end) begin
                addr_d = min_q[rptr_q];
                pass_d = pass_q + 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
            // Local reset lands on the final read edge, rewinding the bank's own
            // address logic for its next fill/read job.
            if (rd_last) begin
                state_d[rptr_q]           = EMPTY;
                bank_resetn_local[rptr_q] = 1'b0;
                rptr_d                    = !rptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= '{EMPTY, EMPTY};
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            addr_q   <= '0;
            pass_q   <= '0;
            rep_q    <= '0;
            vld_pipe <= '0;
            sel_pipe <= '0;
            lst_pipe <= '0;
            for (int b = 0; b < 2; b++) begin
                min_q[b] <= '0;
                max_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            if (cfg_fire) begin
                min_q[rptr_q] <= bus.cfg_addr_min;
                max_q[rptr_q] <= bus.cfg_addr_max;
                rep_q         <= bus.cfg_repeat;
            end
            if (clken) begin
                vld_pipe[1] <= rd_fire;
                sel_pipe[1] <= rptr_q;
                lst_pipe[1] <= rd_last;
                for (int k = 2; k <= LATENCY; k++) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    sel_pipe[k] <= sel_pipe[k-1];
                    lst_pipe[k] <= lst_pipe[k-1];
                end
            end
        end
    end

`ifdef CYCLIC_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cycles <= '0;
            stat_passes       <= '0;
        end else begin
            if (!clken && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
            if (pass_end && stat_passes != '1)
                stat_passes <= stat_passes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cyclic_bram_sched.sv
module tb_cyclic_bram_sched;
    localparam int LAT = 3;
    localparam int AW  = 3;
    localparam int RW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cyclic_bram_sched_if #(.R_ADDR_WIDTH(AW), .REPEAT_WIDTH(RW)) bus();

    logic          clken;
    logic [1:0]    bank_w_en, bank_r_en, bank_resetn_local;
    logic [2*AW-1:0] bank_addr_min, bank_addr_max;
`ifdef CYCLIC_SCHED_STATS_EN
    logic [31:0]   stat_stall_cycles, stat_passes;
`endif

    cyclic_bram_sched #(.R_DEPTH(8), .LATENCY(LAT), .REPEAT_WIDTH(RW), .R_ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .clken             (clken),
        .bank_w_en         (bank_w_en),
        .bank_r_en         (bank_r_en),
        .bank_resetn_local (bank_resetn_local),
        .bank_addr_min     (bank_addr_min),
        .bank_addr_max     (bank_addr_max)
`ifdef CYCLIC_SCHED_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_passes       (stat_passes)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- bank environment: two cyclic BRAMs with read latency ----------
    logic [7:0] mem [2][8];
    int         woff [2] = '{0, 0};
    int         roff [2] = '{0, 0};
    logic [7:0] dpipe [LAT];
    logic [7:0] s_data = 8'h00;

    function automatic logic [7:0] bank_rd(input int b);
        int mn, mx, span;
        mn   = int'(bank_addr_min[b*AW +: AW]);
        mx   = int'(bank_addr_max[b*AW +: AW]);
        span = mx - mn + 1;
        if (span < 1) span = 1;
        return mem[b][(mn + roff[b] % span) % 8];
    endfunction

    always @(posedge clk) begin
        if (clken) begin
            for (int k = LAT-1; k > 0; k--) dpipe[k] <= dpipe[k-1];
            dpipe[0] <= bank_r_en[1] ? bank_rd(1) : (bank_r_en[0] ? bank_rd(0) : 8'h00);
        end
        for (int b = 0; b < 2; b++) begin
            if (!bank_resetn_local[b]) begin
                woff[b] <= 0;
                roff[b] <= 0;
            end else begin
                if (bank_w_en[b]) begin
                    mem[b][woff[b] % 8] <= s_data;
                    woff[b] <= woff[b] + 1;
                end
                if (bank_r_en[b]) roff[b] <= roff[b] + 1;
            end
        end
    end

    // ---------------- reference model: expected beats per job -----------------------
    typedef struct {logic sel; logic last; logic [7:0] data;} beat_t;
    beat_t      exp_q [$];
    logic [7:0] exp_fill [2][8];
    int         exp_wptr = 0;
    int         exp_rptr = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit in_rst = 1'b1;
    int beats  = 0;
    int lat_r  = -1;
    int lat_m  = -1;
    int lowcnt [2] = '{0, 0};
    int pulses [2] = '{0, 0};

    always @(negedge clk) begin
        beat_t e;
        if (!in_rst) begin
            if (lat_r < 0 && bank_r_en != 2'b00) lat_r = cyc;
            if (lat_m < 0 && bus.m_valid) lat_m = cyc;
            chk("w_r_same_bank", {30'd0, bank_w_en & bank_r_en}, 32'd0);
            chk("clken_rule", {31'd0, clken}, {31'd0, !(bus.m_valid && !bus.m_ready)});
            if (bus.m_valid && bus.m_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: m_valid with no beat expected at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_sel", {31'd0, bus.m_sel}, {31'd0, e.sel});
                    chk("m_last", {31'd0, bus.m_last}, {31'd0, e.last});
                    chk("m_data", {24'd0, dpipe[LAT-1]}, {24'd0, e.data});
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (!bank_resetn_local[b]) lowcnt[b]++;
                else if (lowcnt[b] > 0) begin
                    chk("resetn_width", lowcnt[b], 1);
                    pulses[b]++;
                    lowcnt[b] = 0;
                end
            end
        end else begin
            lowcnt[0] = 0;
            lowcnt[1] = 0;
        end
    end

    task automatic fill_bank(input int n, input int gap_max, input logic [7:0] base);
        int b;
        bit acc;
        int t;
        b = exp_wptr;
        for (int k = 0; k < n; k++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) step();
            s_data         = 8'(base + k);
            exp_fill[b][k] = s_data;
            bus.s_valid    = 1'b1;
            bus.s_last     = (k == n-1);
            t = 0;
            do begin
                @(negedge clk);
                acc = bus.s_ready;
                step();
                t++;
            end while (!acc && t < 5000);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL fill_timeout: bank %0d beat %0d never accepted", b, k);
            end
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
        end
        exp_wptr ^= 1;
    endtask

    task automatic run_cfg(input int mn, input int mx, input int rep);
        int b;
        bit acc;
        int t;
        beat_t e;
        b = exp_rptr;
        for (int p = 0; p <= rep; p++)
            for (int a = mn; a <= mx; a++) begin
                e.sel  = (b == 1);
                e.data = exp_fill[b][a];
                e.last = (p == rep) && (a == mx);
                exp_q.push_back(e);
            end
        bus.cfg_addr_min = AW'(mn);
        bus.cfg_addr_max = AW'(mx);
        bus.cfg_repeat   = RW'(rep);
        bus.cfg_valid    = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            acc = bus.cfg_ready;
            step();
            t++;
        end while (!acc && t < 5000);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL cfg_timeout: bank %0d descriptor never accepted", b);
        end
        bus.cfg_valid = 1'b0;
        exp_rptr ^= 1;
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            step();
            t++;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    typedef struct {int len; int mn; int mx; int rep; int exp_beats;} vec_t;
    vec_t vt [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, p0, b0, sc, sr, mv, t;
        int jl [$];
        bit rand_done;

        vt[0] = '{8, 0, 7, 0, 8};
        vt[1] = '{8, 2, 4, 2, 9};
        vt[2] = '{8, 5, 5, 0, 1};
        vt[3] = '{6, 3, 3, 3, 4};
        vt[4] = '{4, 0, 3, 1, 8};
        vt[5] = '{1, 0, 0, 0, 1};

        bus.s_valid = 0; bus.s_last = 0; bus.cfg_valid = 0; bus.cfg_repeat = '0;
        bus.cfg_addr_min = '0; bus.cfg_addr_max = '0; bus.m_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();

        // reset values
        @(negedge clk);
        chk("rst_s_ready", {31'd0, bus.s_ready}, 0);
        chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 0);
        chk("rst_m_last", {31'd0, bus.m_last}, 0);
        chk("rst_m_sel", {31'd0, bus.m_sel}, 0);
        chk("rst_w_en", {30'd0, bank_w_en}, 0);
        chk("rst_r_en", {30'd0, bank_r_en}, 0);
        chk("rst_resetn_local", {30'd0, bank_resetn_local}, 0);
        chk("rst_clken", {31'd0, clken}, 1);
        chk("rst_addr_min", {26'd0, bank_addr_min}, 0);
        chk("rst_addr_max", {26'd0, bank_addr_max}, 0);
        step();
        rst = 1'b0;
        in_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", {31'd0, bus.s_ready}, 1);
        step();

        // table-driven jobs, alternating banks, m_ready held high
        for (int i = 0; i < 6; i++) begin
            lat_r = -1;
            lat_m = -1;
            b  = exp_rptr;
            p0 = pulses[b];
            b0 = beats;
            fill_bank(vt[i].len, 0, 8'(i*16 + 1));
            run_cfg(vt[i].mn, vt[i].mx, vt[i].rep);
            drain(500);
            repeat (2) step();
            chk($sformatf("job%0d_beats", i), beats - b0, vt[i].exp_beats);
            chk($sformatf("job%0d_latency", i), lat_m - lat_r, LAT);
            chk($sformatf("job%0d_resetn_pulses", i), pulses[b] - p0, 1);
        end

        // fill bank1 while bank0 reads, with a 5-cycle output stall mid-pass
        fill_bank(8, 0, 8'h80);
        run_cfg(0, 7, 2);
        b0 = beats;
        fork
            begin
                fill_bank(8, 3, 8'hA0);
                run_cfg(0, 7, 0);
            end
            begin
                t = 0;
                while (!((beats - b0) >= 5 && bus.m_valid) && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                step();
                bus.m_ready = 1'b0;
                sc = 0;
                sr = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (!clken) sc++;
                    if (bus.s_ready) sr++;
                    step();
                end
                bus.m_ready = 1'b1;
                chk("stall_clken_low_cycles", sc, 5);
                chk("stall_s_ready_high_cycles", sr, 0);
            end
        join
        drain(1000);
        repeat (2) step();
        chk("pingpong_total_beats", beats - b0, 32);

        // reset in the middle of a read with the other bank FULL
        fill_bank(8, 0, 8'hC0);
        run_cfg(0, 7, 3);
        fill_bank(8, 0, 8'hD0);
        b0 = beats;
        t = 0;
        while ((beats - b0) < 4 && t < 500) begin
            step();
            t++;
        end
        chk("midread_progress", ((beats - b0) >= 4), 1);
        rst = 1'b1;
        in_rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_valid", {31'd0, bus.m_valid}, 0);
        chk("midrst_s_ready", {31'd0, bus.s_ready}, 0);
        chk("midrst_r_en", {30'd0, bank_r_en}, 0);
        chk("midrst_resetn_local", {30'd0, bank_resetn_local}, 0);
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_wptr = 0;
        exp_rptr = 0;
        in_rst = 1'b0;
        @(negedge clk);
        chk("after_rst_s_ready", {31'd0, bus.s_ready}, 1);
        chk("after_rst_cfg_ready", {31'd0, bus.cfg_ready}, 0);
        chk("after_rst_addr_min", {26'd0, bank_addr_min}, 0);
        mv = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.m_valid) mv++;
        end
        chk("after_rst_no_m_valid", mv, 0);
        step();

        // randomized jobs with random output back-pressure
        rand_done = 1'b0;
        b0 = beats;
        fork
            begin
                for (int j = 0; j < 12; j++) begin
                    int len;
                    len = $urandom_range(8, 1);
                    fill_bank(len, 2, 8'($urandom));
                    jl.push_back(len);
                end
            end
            begin
                for (int j = 0; j < 12; j++) begin
                    int len, mn, mx, rep, tw;
                    tw = 0;
                    while (jl.size() == 0 && tw < 5000) begin
                        step();
                        tw++;
                    end
                    if (jl.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_fill_timeout: job %0d never filled", j);
                        break;
                    end
                    len = jl.pop_front();
                    mn  = $urandom_range(len-1, 0);
                    mx  = $urandom_range(len-1, mn);
                    rep = $urandom_range(2, 0);
                    run_cfg(mn, mx, rep);
                end
                drain(5000);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.m_ready = ($urandom_range(3, 0) != 0);
                    step();
                end
                bus.m_ready = 1'b1;
            end
        join
        repeat (LAT + 3) step();
        chk("rand_no_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
